// File: rtl/half_adder_unit_if.sv
// Operand/result bundle for half_adder_unit: A/B/in_valid/clr_cnt in, sum/carry paths out.
interface half_adder_unit_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             clr_cnt;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] S_q;
    logic [WIDTH-1:0] C_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output A, B, in_valid, clr_cnt,
        input  S, C, S_q, C_q, out_valid, carry_cnt
    );

    modport slave (
        input  A, B, in_valid, clr_cnt,
        output S, C, S_q, C_q, out_valid, carry_cnt
    );
endinterface

// File: rtl/half_adder_unit.sv
// WIDTH independent half-adder lanes with combinational outputs, a one-cycle
// registered copy qualified by in_valid, and a saturating carry-event counter.
module half_adder_unit #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    half_adder_unit_if.slave   bus
);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             any_carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        sum       = bus.A ^ bus.B;
        carry     = bus.A & bus.B;
        any_carry = |carry;
    end

    // Registered copy holds its last value while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
            end
        end
    end

    // Clear wins over increment; counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            cnt_q <= '0;
        end else if (bus.in_valid && any_carry && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.S         = sum;
        bus.C         = carry;
        bus.S_q       = sum_q;
        bus.C_q       = carry_q;
        bus.out_valid = valid_q;
        bus.carry_cnt = cnt_q;
    end
endmodule

// File: tb/tb_half_adder_unit.sv
// Directed bench: single-lane unit with a 2-bit counter plus a 4-lane unit.
module tb_half_adder_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    half_adder_unit_if #(.WIDTH(1), .CNT_W(2)) bus1 ();
    half_adder_unit_if #(.WIDTH(4), .CNT_W(8)) bus4 ();

    half_adder_unit #(.WIDTH(1), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    half_adder_unit #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.A = 1'b0; bus1.B = 1'b0; bus1.in_valid = 1'b0; bus1.clr_cnt = 1'b0;
        bus4.A = 4'b0; bus4.B = 4'b0; bus4.in_valid = 1'b0; bus4.clr_cnt = 1'b0;
        #3;
        checks++;
        if ({bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt} !== 5'b0) begin
            errors++;
            $display("FAIL reset1 got S_q=%b C_q=%b ov=%b cnt=%0d want all 0",
                     bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt);
        end
        checks++;
        if ({bus4.S_q, bus4.C_q, bus4.out_valid, bus4.carry_cnt} !== 17'b0) begin
            errors++;
            $display("FAIL reset4 got S_q=%b C_q=%b ov=%b cnt=%0d want all 0",
                     bus4.S_q, bus4.C_q, bus4.out_valid, bus4.carry_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_truth_table();
        logic [1:0] ab  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [1:0] sc  [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        logic [1:0] cnt [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            bus1.A = ab[i][1];
            bus1.B = ab[i][0];
            bus1.in_valid = 1'b1;
            #1;
            checks++;
            if ({bus1.S, bus1.C} !== sc[i]) begin
                errors++;
                $display("FAIL tt_comb[%0d] got S,C=%b%b want %b", i, bus1.S, bus1.C, sc[i]);
            end
            next_cycle();
            checks++;
            if ({bus1.S_q, bus1.C_q, bus1.out_valid} !== {sc[i], 1'b1}) begin
                errors++;
                $display("FAIL tt_reg[%0d] got S_q,C_q,ov=%b%b%b want %b1",
                         i, bus1.S_q, bus1.C_q, bus1.out_valid, sc[i]);
            end
            checks++;
            if (bus1.carry_cnt !== cnt[i]) begin
                errors++;
                $display("FAIL tt_cnt[%0d] got %0d want %0d", i, bus1.carry_cnt, cnt[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            checks++;
            if ({bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt} !== 5'b01001) begin
                errors++;
                $display("FAIL gating[%0d] got S_q=%b C_q=%b ov=%b cnt=%0d want 0 1 0 1",
                         i, bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus1.clr_cnt = 1'b1;
        next_cycle();
        bus1.clr_cnt = 1'b0;
        checks++;
        if (bus1.carry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clear got %0d want 0", bus1.carry_cnt);
        end
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checks++;
            if (bus1.carry_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL sat[%0d] got %0d want %0d", i, bus1.carry_cnt, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_clear_priority();
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.in_valid = 1'b1; bus1.clr_cnt = 1'b1;
        next_cycle();
        bus1.clr_cnt = 1'b0;
        checks++;
        if (bus1.carry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clr_prio got %0d want 0", bus1.carry_cnt);
        end
        next_cycle();
        checks++;
        if (bus1.carry_cnt !== 2'd1) begin
            errors++;
            $display("FAIL clr_resume got %0d want 1", bus1.carry_cnt);
        end
    endtask

    task automatic test_reset_midop();
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.in_valid = 1'b1;
        bus4.A = 4'b1111; bus4.B = 4'b1111; bus4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        checks++;
        if ({bus1.C_q, bus1.out_valid, bus1.carry_cnt} !== 4'b1111) begin
            errors++;
            $display("FAIL pre_rst got C_q=%b ov=%b cnt=%0d want 1 1 3",
                     bus1.C_q, bus1.out_valid, bus1.carry_cnt);
        end
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt} !== 5'b0) begin
            errors++;
            $display("FAIL async_rst got S_q=%b C_q=%b ov=%b cnt=%0d want all 0",
                     bus1.S_q, bus1.C_q, bus1.out_valid, bus1.carry_cnt);
        end
        checks++;
        if ({bus1.S, bus1.C} !== 2'b01) begin
            errors++;
            $display("FAIL rst_comb got S,C=%b%b want 01", bus1.S, bus1.C);
        end
        checks++;
        if ({bus4.C_q, bus4.out_valid, bus4.carry_cnt} !== 13'b0) begin
            errors++;
            $display("FAIL async_rst4 got C_q=%b ov=%b cnt=%0d want all 0",
                     bus4.C_q, bus4.out_valid, bus4.carry_cnt);
        end
        bus1.in_valid = 1'b0;
        bus4.A = 4'b0; bus4.B = 4'b0; bus4.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_multi_lane();
        bus4.A = 4'b1100; bus4.B = 4'b1010; bus4.in_valid = 1'b1;
        #1;
        checks++;
        if ({bus4.S, bus4.C} !== 8'b0110_1000) begin
            errors++;
            $display("FAIL lanes_comb got S=%b C=%b want 0110 1000", bus4.S, bus4.C);
        end
        next_cycle();
        bus4.A = 4'b1111; bus4.B = 4'b0001;
        checks++;
        if ({bus4.S_q, bus4.C_q, bus4.out_valid, bus4.carry_cnt} !== {8'b0110_1000, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL lanes_reg got S_q=%b C_q=%b ov=%b cnt=%0d want 0110 1000 1 1",
                     bus4.S_q, bus4.C_q, bus4.out_valid, bus4.carry_cnt);
        end
        next_cycle();
        bus4.in_valid = 1'b0;
        checks++;
        if ({bus4.S_q, bus4.C_q, bus4.carry_cnt} !== {8'b1110_0001, 8'd2}) begin
            errors++;
            $display("FAIL lanes_b2b got S_q=%b C_q=%b cnt=%0d want 1110 0001 2",
                     bus4.S_q, bus4.C_q, bus4.carry_cnt);
        end
        next_cycle();
        checks++;
        if ({bus4.S_q, bus4.out_valid, bus4.carry_cnt} !== {4'b1110, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL lanes_idle got S_q=%b ov=%b cnt=%0d want 1110 0 2",
                     bus4.S_q, bus4.out_valid, bus4.carry_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_truth_table();
        test_valid_gating();
        test_saturation();
        test_clear_priority();
        test_reset_midop();
        test_multi_lane();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/half_adder_unit.md
Name: half_adder_unit

Overview:
- Bit-parallel half-adder array. Each of WIDTH independent lanes computes sum = A xor B and carry = A and B.
- Provides combinational outputs S/C, which are exact half-adder truth-table results.
- Also provides a one-cycle registered copy with valid flag, plus a saturating count of carry-producing cycles.
- Used as a basic arithmetic leaf cell; WIDTH=1 is the plain single-bit half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 8, width of the carry-event counter (>=1).

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  asynchronous active-low reset; deasserts synchronously externally.
- A  input  WIDTH  addend A, one bit per lane.
- B  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies A/B for the registered path and counter.
- S  output  WIDTH  combinational sum, S[i] = A[i] ^ B[i].
- C  output  WIDTH  combinational carry, C[i] = A[i] & B[i].
- S_q  output  WIDTH  registered sum.
- C_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid.
- carry_cnt  output  CNT_W  saturating count of valid cycles with any carry.
- clr_cnt  input  1  synchronous clear of carry_cnt.

Behaviour:
- S, C combinational:
  - Pure functions of A, B.
  - Independent of clk, rst_n and in_valid.
  - Zero latency; settle within the same delta.
- Per lane truth table (A,B -> S,C): 0,0->0,0; 1,0->1,0; 0,1->1,0; 1,1->0,1.
- Registered path:
  - On rising clk with in_valid=1: S_q<=A^B, C_q<=A&B, out_valid<=1.
  - On rising clk with in_valid=0: S_q/C_q hold, out_valid<=0.
  - Latency exactly 1 cycle.
- carry_cnt:
  - On rising clk: if clr_cnt=1, carry_cnt<=0 (clr_cnt has priority over increment).
  - Else if in_valid=1 and |(A&B)=1, increment by 1.
  - Saturates at all-ones and never wraps.
- Reset:
  - rst_n low immediately, without waiting for clk, forces S_q=0, C_q=0, out_valid=0, carry_cnt=0.
  - Reset asserted mid-operation discards any in-flight result.
  - S/C are unaffected by reset and keep tracking A/B.
- No back-pressure: every valid input produces output one cycle later; no ready signal.
- X/unknown inputs are not sanitized; outputs follow the logic operators.
- Lanes are fully independent; there is no inter-lane carry propagation.

Test Plan:
- Exhaustive truth table, WIDTH=1, 20 ns per step (A,B) = 00, 10, 01, 11 -> S,C = 0,0; 1,0; 1,0; 0,1 combinationally. Same values appear on S_q/C_q one cycle later with out_valid=1.
- Reset: drive A=1, B=1, in_valid=1 for 3 cycles, then pull rst_n low between edges -> S_q, C_q, out_valid, carry_cnt go to 0 immediately; S stays 0 and C stays 1.
- Valid gating: in_valid=0 with A=B=1 for 4 cycles -> carry_cnt unchanged, out_valid=0, S_q/C_q hold previous value.
- Counter saturation, CNT_W=2: 5 valid cycles with A=B=1 -> carry_cnt = 1, 2, 3, 3, 3.
- Clear priority: clr_cnt=1 and in_valid=1, A=B=1 in the same cycle -> carry_cnt=0 after the edge.
- Multi-lane, WIDTH=4: A=4'b1100, B=4'b1010 -> S=4'b0110, C=4'b1000, with no inter-lane carry. A valid cycle increments carry_cnt by 1.
